// File: rtl/ladybird_bus_arbiter_if.sv
// ladybird_bus_arbiter_if: address map and core/peripheral bus bundle for the arbiter
package ladybird_config;
    localparam int XLEN = 32;
    localparam int NUM_PERIPHERAL = 6;
    typedef enum logic {D_BUS = 1'b0, I_BUS = 1'b1} core_bus_t;
    typedef enum logic [2:0] {IRAM, BRAM, DRAM, UART, QSPI, GPIO} access_t;
    // Region is chosen by the top address nibble; unmapped space falls to DRAM.
    function automatic access_t ACCESS_TYPE(input logic [3:0] region);
        return region == 4'hF ? UART : region == 4'hE ? GPIO : region == 4'hD ? QSPI :
               region == 4'h8 ? BRAM : region == 4'h9 ? IRAM : DRAM;
    endfunction
endpackage

interface ladybird_bus_arbiter_if;
    import ladybird_config::*;
    logic [1:0][XLEN-1:0] core_addr;
    logic [1:0][XLEN-1:0] core_wdata;
    logic [1:0][3:0] core_wstrb;
    logic [1:0] core_valid;
    logic [1:0] core_ready;
    logic [XLEN-1:0] core_rdata;
    logic core_resp_err;
    logic [1:0] core_resp_valid;
    logic [1:0] core_resp_ready;
    logic [XLEN-1:0] periph_addr;
    logic [XLEN-1:0] periph_wdata;
    logic [3:0] periph_wstrb;
    logic [NUM_PERIPHERAL-1:0] periph_valid;
    logic [NUM_PERIPHERAL-1:0] periph_ready;
    logic [NUM_PERIPHERAL-1:0][XLEN-1:0] periph_rdata;
    logic [NUM_PERIPHERAL-1:0] periph_resp_valid;
    logic periph_resp_ready;
    modport master (
        output core_addr, core_wdata, core_wstrb, core_valid, core_resp_ready,
        output periph_ready, periph_rdata, periph_resp_valid,
        input core_ready, core_rdata, core_resp_err, core_resp_valid,
        input periph_addr, periph_wdata, periph_wstrb, periph_valid, periph_resp_ready
    );
    modport slave (
        input core_addr, core_wdata, core_wstrb, core_valid, core_resp_ready,
        input periph_ready, periph_rdata, periph_resp_valid,
        output core_ready, core_rdata, core_resp_err, core_resp_valid,
        output periph_addr, periph_wdata, periph_wstrb, periph_valid, periph_resp_ready
    );
endinterface

// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter: round-robin two-core arbiter routing one transaction at a time to a peripheral
module ladybird_bus_arbiter
    import ladybird_config::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rstn,
    ladybird_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    state_t state;
    core_bus_t grant, last_grant;
    access_t target, req_tgt;
    logic [31:0] cnt;
    logic pick, start, done, expire;
    // Arbitration pick, completion/timeout detection and the pass-through response paths.
    always_comb begin
        pick = (bus.core_valid[0] & bus.core_valid[1]) ? ~last_grant : bus.core_valid[1];
        start = state == IDLE && |bus.core_valid;
        req_tgt = ACCESS_TYPE(bus.core_addr[pick][XLEN-1 -: 4]);
        done = state == RESP && bus.periph_resp_valid[target] && bus.core_resp_ready[grant];
        expire = TIMEOUT_CYCLES != 0 && cnt >= 32'(TIMEOUT_CYCLES - 1);
        bus.core_ready = (rstn && start) ? 2'b01 << pick : 2'b00;
        bus.core_resp_valid = (state == ERR || (state == RESP && bus.periph_resp_valid[target])) ? 2'b01 << grant : 2'b00;
        bus.core_resp_err = state == ERR;
        bus.core_rdata = state == RESP ? bus.periph_rdata[target] : '0;
        bus.periph_resp_ready = rstn && (state == IDLE || (state == RESP && bus.core_resp_ready[grant]));
    end
    // Transaction FSM with request latching and the grant-to-response watchdog.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= D_BUS;
            last_grant <= I_BUS;
            target <= IRAM;
            cnt <= '0;
            bus.periph_addr <= '0;
            bus.periph_wdata <= '0;
            bus.periph_wstrb <= '0;
            bus.periph_valid <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    grant <= core_bus_t'(pick);
                    target <= req_tgt;
                    cnt <= '0;
                    bus.periph_addr <= bus.core_addr[pick];
                    bus.periph_wdata <= bus.core_wdata[pick];
                    bus.periph_wstrb <= bus.core_wstrb[pick];
                    bus.periph_valid <= NUM_PERIPHERAL'(1) << req_tgt;
                    state <= REQ;
                end
                REQ: begin
                    cnt <= cnt + 32'd1;
                    if (bus.periph_ready[target]) begin
                        bus.periph_valid <= '0;
                        state <= RESP;
                    end else if (expire) begin
                        bus.periph_valid <= '0;
                        state <= ERR;
                    end
                end
                RESP: begin
                    cnt <= cnt + 32'd1;
                    if (done) begin
                        last_grant <= grant;
                        state <= IDLE;
                    end else if (expire) begin
                        state <= ERR;
                    end
                end
                default: if (bus.core_resp_ready[grant]) begin
                    last_grant <= grant;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb_ladybird_bus_arbiter: directed self-checking bench for the two-core bus arbiter
module tb_ladybird_bus_arbiter;
    import ladybird_config::*;
    logic clk = 1'b0;
    logic rstn;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] sw_a [6] = '{32'hF000_0004, 32'hE000_0008, 32'hD000_000C, 32'h8000_0100, 32'h9000_0200, 32'h0000_0300};
    int sw_t [6] = '{3, 5, 4, 1, 0, 2};

    ladybird_bus_arbiter_if bus();
    ladybird_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    // Free-running core clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL sim_timeout observed=stalled expected=finished");
        $fatal(1, "sim timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input int c, input logic [31:0] a, input int t, input logic [31:0] d);
        chk("grant", 32'(bus.core_ready), 32'(1) << c);
        tick;
        bus.core_valid[c] = 1'b0;
        #1;
        chk("req_pvalid", 32'(bus.periph_valid), 32'(1) << t);
        chk("req_paddr", bus.periph_addr, a);
        chk("req_pwdata", bus.periph_wdata, bus.core_wdata[c]);
        chk("req_pwstrb", 32'(bus.periph_wstrb), 32'(bus.core_wstrb[c]));
        chk("req_prr", 32'(bus.periph_resp_ready), 0);
        bus.periph_ready[t] = 1'b1;
        #1;
        tick;
        bus.periph_ready[t] = 1'b0;
        bus.periph_rdata[t] = d;
        bus.periph_resp_valid[t] = 1'b1;
        bus.core_resp_ready[c] = 1'b1;
        #1;
        chk("resp_valid", 32'(bus.core_resp_valid), 32'(1) << c);
        chk("resp_rdata", bus.core_rdata, d);
        chk("resp_err", 32'(bus.core_resp_err), 0);
        chk("resp_prr", 32'(bus.periph_resp_ready), 1);
        chk("resp_pvalid", 32'(bus.periph_valid), 0);
        tick;
        bus.periph_resp_valid[t] = 1'b0;
        bus.core_resp_ready[c] = 1'b0;
        #1;
        chk("idle_rvalid", 32'(bus.core_resp_valid), 0);
    endtask

    initial begin
        rstn = 1'b0;
        bus.core_addr = '0;
        bus.core_wdata = '0;
        bus.core_wstrb = '0;
        bus.core_valid = '0;
        bus.core_resp_ready = '0;
        bus.periph_ready = '0;
        bus.periph_rdata = '0;
        bus.periph_resp_valid = '0;
        #12;
        chk("rst_core_ready", 32'(bus.core_ready), 0);
        chk("rst_pvalid", 32'(bus.periph_valid), 0);
        chk("rst_paddr", bus.periph_addr, 0);
        chk("rst_pwdata", bus.periph_wdata, 0);
        chk("rst_pwstrb", 32'(bus.periph_wstrb), 0);
        chk("rst_rdata", bus.core_rdata, 0);
        chk("rst_err", 32'(bus.core_resp_err), 0);
        chk("rst_rvalid", 32'(bus.core_resp_valid), 0);
        chk("rst_prr", 32'(bus.periph_resp_ready), 0);
        rstn = 1'b1;
        #1;
        chk("idle_prr", 32'(bus.periph_resp_ready), 1);

        bus.core_addr[0] = 32'hF000_0000;
        bus.core_addr[1] = 32'h9000_0000;
        bus.core_valid = 2'b11;
        #1;
        xact(0, 32'hF000_0000, 3, 32'h1111_1111);
        xact(1, 32'h9000_0000, 0, 32'h2222_2222);
        bus.core_valid = 2'b11;
        #1;
        xact(0, 32'hF000_0000, 3, 32'h3333_3333);
        xact(1, 32'h9000_0000, 0, 32'h4444_4444);

        bus.core_addr[0] = 32'h8000_0010;
        bus.core_valid[0] = 1'b1;
        #1;
        xact(0, 32'h8000_0010, 1, 32'hDEAD_BEEF);

        for (int i = 0; i < 6; i++) begin
            bus.core_addr[0] = sw_a[i];
            bus.core_wdata[0] = 32'hA5A5_0000 + 32'(i);
            bus.core_wstrb[0] = (i % 2 == 1) ? 4'hF : 4'h0;
            bus.core_valid[0] = 1'b1;
            #1;
            xact(0, sw_a[i], sw_t[i], 32'h5000_0000 + 32'(i));
        end
        bus.core_wstrb[0] = 4'h0;

        bus.core_addr[0] = 32'h0000_0040;
        bus.core_addr[1] = 32'hE000_0000;
        bus.core_valid[0] = 1'b1;
        #1;
        chk("hold_grant", 32'(bus.core_ready), 1);
        tick;
        bus.core_valid[0] = 1'b0;
        bus.core_valid[1] = 1'b1;
        bus.periph_ready[2] = 1'b1;
        #1;
        chk("hold_pvalid", 32'(bus.periph_valid), 32'h4);
        tick;
        bus.periph_ready[2] = 1'b0;
        bus.periph_rdata[2] = 32'hCAFE_F00D;
        bus.periph_resp_valid[2] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_prr", 32'(bus.periph_resp_ready), 0);
            chk("hold_rdata", bus.core_rdata, 32'hCAFE_F00D);
            chk("hold_rvalid", 32'(bus.core_resp_valid), 1);
            chk("hold_no_grant", 32'(bus.core_ready), 0);
            tick;
        end
        bus.core_resp_ready[0] = 1'b1;
        #1;
        chk("hold_release_prr", 32'(bus.periph_resp_ready), 1);
        tick;
        bus.periph_resp_valid[2] = 1'b0;
        bus.core_resp_ready[0] = 1'b0;
        #1;
        xact(1, 32'hE000_0000, 5, 32'h6666_6666);

        bus.core_addr[0] = 32'hD000_0000;
        bus.core_valid[0] = 1'b1;
        #1;
        chk("to_grant", 32'(bus.core_ready), 1);
        tick;
        bus.core_valid[0] = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_err", 32'(bus.core_resp_err), 0);
            chk("to_wait_rvalid", 32'(bus.core_resp_valid), 0);
            chk("to_wait_pvalid", 32'(bus.periph_valid), 32'h10);
            tick;
        end
        chk("to_err", 32'(bus.core_resp_err), 1);
        chk("to_rvalid", 32'(bus.core_resp_valid), 1);
        chk("to_rdata", bus.core_rdata, 0);
        chk("to_pvalid", 32'(bus.periph_valid), 0);
        chk("to_prr", 32'(bus.periph_resp_ready), 0);
        tick;
        chk("to_err_held", 32'(bus.core_resp_err), 1);
        bus.core_resp_ready[0] = 1'b1;
        #1;
        tick;
        bus.core_resp_ready[0] = 1'b0;
        bus.periph_rdata[4] = 32'hBAD0_BAD0;
        bus.periph_resp_valid[4] = 1'b1;
        #1;
        chk("drain_prr", 32'(bus.periph_resp_ready), 1);
        chk("drain_rvalid", 32'(bus.core_resp_valid), 0);
        chk("drain_rdata", bus.core_rdata, 0);
        chk("drain_err", 32'(bus.core_resp_err), 0);
        chk("drain_no_grant", 32'(bus.core_ready), 0);
        tick;
        bus.periph_resp_valid[4] = 1'b0;

        bus.core_addr[0] = 32'h8000_0020;
        bus.core_addr[1] = 32'h9000_0040;
        bus.core_valid[0] = 1'b1;
        #1;
        chk("rr_grant", 32'(bus.core_ready), 1);
        tick;
        #1;
        chk("rr_pvalid", 32'(bus.periph_valid), 32'h2);
        bus.core_valid = 2'b11;
        rstn = 1'b0;
        #1;
        chk("rr_pvalid0", 32'(bus.periph_valid), 0);
        chk("rr_paddr0", bus.periph_addr, 0);
        chk("rr_ready0", 32'(bus.core_ready), 0);
        chk("rr_prr0", 32'(bus.periph_resp_ready), 0);
        chk("rr_rvalid0", 32'(bus.core_resp_valid), 0);
        #2;
        rstn = 1'b1;
        #1;
        xact(0, 32'h8000_0020, 1, 32'h7777_7777);
        xact(1, 32'h9000_0040, 0, 32'h8888_8888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
